// File: rtl/mux_project_sequencer.sv
// Sequencer for the shared muxed project slots: owns the one-hot enable, the
// project reset bit and the return-mux index, with break-before-make switching.
module mux_project_sequencer #(
  parameter int N_PROJ       = 16,
  parameter int IDX_W        = 4,
  parameter int DRAIN_CYCLES = 2,
  parameter int RST_CYCLES   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel_valid,
  output logic              sel_ready,
  input  logic [IDX_W-1:0]  sel_idx,
  input  logic              sel_off,
  input  logic              user_rst_n,
  output logic [N_PROJ-1:0] ena,
  output logic              proj_rst_n,
  output logic [IDX_W-1:0]  cur_idx,
  output logic              active,
  output logic              busy,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, DRAIN, LOAD, RESET, RUN} state_t;

  localparam int CNT_W = 8;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   req_idx;
  logic               req_off;
  logic               accept;
  logic               idx_bad;

  assign accept  = sel_valid && sel_ready;
  assign idx_bad = !sel_off && (32'(sel_idx) >= N_PROJ);

  function automatic logic [N_PROJ-1:0] onehot(input logic [IDX_W-1:0] idx);
    return {{(N_PROJ-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Outputs are computed for the state being entered, so every output is a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ena        <= '0;
      proj_rst_n <= 1'b0;
      cur_idx    <= '0;
      active     <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      sel_ready  <= 1'b1;
      cnt        <= '0;
      req_idx    <= '0;
      req_off    <= 1'b0;
    end else begin
      err <= accept && idx_bad;
      case (state)
        IDLE: begin
          if (accept && !sel_off && !idx_bad) begin
            state      <= LOAD;
            req_idx    <= sel_idx;
            req_off    <= 1'b0;
            cur_idx    <= sel_idx;
            ena        <= '0;
            proj_rst_n <= 1'b0;
            busy       <= 1'b1;
            sel_ready  <= 1'b0;
          end
        end
        RUN: begin
          proj_rst_n <= user_rst_n;
          if (accept && !idx_bad) begin
            state      <= DRAIN;
            req_idx    <= sel_idx;
            req_off    <= sel_off;
            cnt        <= CNT_W'(DRAIN_CYCLES - 1);
            proj_rst_n <= 1'b0;
            active     <= 1'b0;
            busy       <= 1'b1;
            sel_ready  <= 1'b0;
          end
        end
        // The old project keeps its enable while held in reset, then drops it
        // one full cycle before the new enable appears.
        DRAIN: begin
          if (cnt == '0) begin
            ena <= '0;
            if (req_off) begin
              state     <= IDLE;
              busy      <= 1'b0;
              sel_ready <= 1'b1;
            end else begin
              state   <= LOAD;
              cur_idx <= req_idx;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        LOAD: begin
          state <= RESET;
          ena   <= onehot(cur_idx);
          cnt   <= CNT_W'(RST_CYCLES - 1);
        end
        RESET: begin
          if (cnt == '0) begin
            state      <= RUN;
            active     <= 1'b1;
            busy       <= 1'b0;
            sel_ready  <= 1'b1;
            proj_rst_n <= user_rst_n;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          ena        <= '0;
          proj_rst_n <= 1'b0;
          active     <= 1'b0;
          busy       <= 1'b0;
          sel_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/mux_project_sequencer.md
Name: mux_project_sequencer

Overview:
- Sequences the shared muxed project slots: selects one project, drives its one-hot `ena`, and runs an orderly reset/switch sequence.
- The shared `iw`/`ow` buses never see two active projects, and no project leaves reset mid-switch.
- Sits above the array of per-project wrappers and drives `ena` for each wrapper.
- Supplies the project reset bit that the top level packs into `iw[1]`, and the index that steers the `ow` return mux.

Parameters:
- N_PROJ, 16, number of project wrappers sharing the bus (2..256).
- IDX_W, 4, width of the project index; must satisfy 2**IDX_W >= N_PROJ.
- DRAIN_CYCLES, 2, cycles the old project stays enabled with reset asserted before being disabled (1..15).
- RST_CYCLES, 8, cycles the new project is held in reset after enable (1..255).

Ports:
- clk  input  1  system clock, also the clock forwarded on `iw[0]`.
- rst  input  1  asynchronous active-high reset.
- sel_valid  input  1  selection request valid.
- sel_ready  output  1  sequencer can accept a request.
- sel_idx  input  IDX_W  requested project index.
- sel_off  input  1  with `sel_valid`: deselect all projects; `sel_idx` is ignored.
- user_rst_n  input  1  user reset for the running project, active-low.
- ena  output  N_PROJ  one-hot (or all-zero) project enable.
- proj_rst_n  output  1  reset to the active project (`iw[1]`).
- cur_idx  output  IDX_W  index steering the `ow` mux.
- active  output  1  a project is in RUN.
- busy  output  1  a switch sequence is in progress.
- err  output  1  one-cycle pulse: index out of range was rejected.

Behaviour:
- All outputs are registered. Requests are accepted on `sel_valid && sel_ready` at a clock edge.
- On `rst`, asynchronously:
  - state=IDLE, `ena`=0, `proj_rst_n`=0, `cur_idx`=0, `active`=0, `busy`=0, `err`=0, `sel_ready`=1.
  - The async reset can land mid-sequence (see boundaries); no further edges are required to reach this state.
- States: IDLE, DRAIN, LOAD, RESET, RUN. `sel_ready`=1 only in IDLE and RUN; `busy`=1 in DRAIN, LOAD and RESET.
- IDLE: `ena`=0, `proj_rst_n`=0.
  - Valid index accepted → LOAD.
  - `sel_off` accepted → stay in IDLE, no effect.
- RUN: `ena`=onehot(`cur_idx`), `proj_rst_n`=`user_rst_n` registered (1-cycle latency), `active`=1.
  - Any accepted request → DRAIN.
- DRAIN: `ena` unchanged, `proj_rst_n`=0 from the first DRAIN cycle. This gives the old project DRAIN_CYCLES clocks under reset.
  - After DRAIN_CYCLES cycles: to IDLE if the stored request was `sel_off`, else to LOAD.
- LOAD (exactly 1 cycle): `ena`=0 (break-before-make), `cur_idx`←stored index, `proj_rst_n`=0 → RESET.
- RESET: `ena`=onehot(`cur_idx`), `proj_rst_n`=0 for RST_CYCLES cycles → RUN.
- Request storage: the request is captured into an internal register at acceptance. `sel_idx` and `sel_off` may change afterwards without effect.
- Index check at acceptance: `sel_idx` >= N_PROJ with `sel_off`=0:
  - request is consumed (ready handshake completes);
  - `err`=1 for the next cycle;
  - state, `ena` and `cur_idx` are unchanged (RUN stays RUN, IDLE stays IDLE).
- Reselecting the current index from RUN is legal and performs a full DRAIN/LOAD/RESET re-reset.
- `ena` is never multi-hot in any cycle, including across LOAD.
- `cur_idx` changes only in LOAD and on `rst`.
- `user_rst_n` is ignored outside RUN.
- Counters are internal, sized for the maximum parameter values, reloaded on every state entry, and never wrap.
- Latencies, from the accepting edge:
  - From RUN: new `ena` visible after DRAIN_CYCLES+1 cycles; `active` rises after DRAIN_CYCLES+1+RST_CYCLES cycles.
  - From IDLE: new `ena` visible after 1 cycle.

Test Plan:
- Defaults; from IDLE request idx 3 → after accept, 1 cycle `ena`=0 with `cur_idx`=3; then `ena`=0x0008 with `proj_rst_n`=0 for 8 cycles; then `active`=1.
- RUN idx 3, request idx 5 → `proj_rst_n`=0 next cycle with `ena`=0x0008 for 2 cycles; then `ena`=0 for 1 cycle; then `ena`=0x0020 and 8 reset cycles; at no cycle is `ena` multi-hot.
- RUN idx 5, request `sel_idx`=15 with N_PROJ=12 → `err` pulses 1 cycle; `ena` stays 0x0020; `active` stays 1; `sel_ready` stays 1.
- RUN, `sel_off` → 2 drain cycles, then `ena`=0, `active`=0, state IDLE; a following `sel_off` has no effect.
- RUN, toggle `user_rst_n` 1→0→1 → `proj_rst_n` follows with 1-cycle delay; `sel_valid` held high while `busy` → `sel_ready`=0 and no request is consumed.
- Assert `rst` mid-RESET (cycle 4 of 8) → `ena`=0, `proj_rst_n`=0, `cur_idx`=0, `busy`=0 immediately without a clock edge; after release a new request sequences normally.
